// File: rtl/div_seq_writer_if.sv
//==============================================================================
// Module   : div_seq_writer_if
// Purpose  : Start/operand request and result-write bus of the sequential
//            divider writer.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

interface div_seq_writer_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] wr_data;
    logic             wr_sel;
    logic             wr;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    // master issues divisions, slave is the divider
    modport master (
        output start, dividend, divisor,
        input  wr_data, wr_sel, wr, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output wr_data, wr_sel, wr, busy, done, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/div_seq_writer.sv
//==============================================================================
// Module   : div_seq_writer
// Purpose  : Unsigned restoring divider that writes quotient then remainder
//            to an external register pair using a set-up/strobe sequence.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module div_seq_writer #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    div_seq_writer_if.slave   bus
);

    localparam int                c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CALC     = 3'd1,
        Q_SETUP  = 3'd2,
        Q_STROBE = 3'd3,
        R_SETUP  = 3'd4,
        R_STROBE = 3'd5,
        FIN      = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dsr;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_wr_data;
    logic               r_wr_sel;
    logic               r_wr;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic [WIDTH-1:0]   w_data_nxt;
    logic               w_sel_nxt;
    logic               w_wr_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_dsr_zero;
    logic [WIDTH+1:0]   w_trial;
    logic               w_ge;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_rem_step;
    logic [WIDTH-1:0]   w_quo_step;

    assign w_dsr_zero = (bus.divisor == '0);

    // r_quo starts as the dividend and shifts left, collecting quotient bits
    assign w_trial    = {r_rem, r_quo[WIDTH-1]};
    assign w_ge       = (w_trial >= {2'b00, r_dsr});
    assign w_diff     = w_trial[WIDTH:0] - {1'b0, r_dsr};
    assign w_rem_step = w_ge ? w_diff : w_trial[WIDTH:0];
    assign w_quo_step = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wr_data <= '0;
            r_wr_sel  <= 1'b0;
            r_wr      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_data <= w_data_nxt;
            r_wr_sel  <= w_sel_nxt;
            r_wr      <= w_wr_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Outputs are registered from the next state, so they align with it
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_wr_data;
        w_sel_nxt   = r_wr_sel;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    if (w_dsr_zero) begin
                        w_state_nxt = Q_SETUP;
                        w_data_nxt  = '1;
                        w_sel_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = Q_SETUP;
                    w_data_nxt  = w_quo_step;
                    w_sel_nxt   = 1'b0;
                end
            end
            Q_SETUP:  w_state_nxt = Q_STROBE;
            Q_STROBE: begin
                w_state_nxt = R_SETUP;
                w_data_nxt  = r_rem[WIDTH-1:0];
                w_sel_nxt   = 1'b1;
            end
            R_SETUP:  w_state_nxt = R_STROBE;
            R_STROBE: w_state_nxt = FIN;
            FIN:      w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        w_wr_nxt   = (w_state_nxt == Q_STROBE) || (w_state_nxt == R_STROBE);
        w_busy_nxt = (w_state_nxt != IDLE) && (w_state_nxt != FIN);
        w_done_nxt = (w_state_nxt == FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dsr <= '0;
            r_cnt <= '0;
            r_dbz <= 1'b0;
        end else if ((r_state == IDLE) && bus.start) begin
            r_quo <= w_dsr_zero ? '1 : bus.dividend;
            r_rem <= w_dsr_zero ? {1'b0, bus.dividend} : '0;
            r_dsr <= bus.divisor;
            r_cnt <= '0;
            r_dbz <= w_dsr_zero;
        end else if (r_state == CALC) begin
            r_rem <= w_rem_step;
            r_quo <= w_quo_step;
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign bus.wr_data     = r_wr_data;
    assign bus.wr_sel      = r_wr_sel;
    assign bus.wr          = r_wr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_writer.sv
//==============================================================================
// Module   : tb_div_seq_writer
// Purpose  : Self-checking bench for div_seq_writer against a cycle-schedule
//            reference model of the divide-and-write sequence.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_div_seq_writer;

    localparam int W = 16;
    localparam int c_RAND_OPS = 1000;
    localparam int c_RAND_LIMIT = 60000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_seq_writer_if #(.WIDTH(W)) bus();

    div_seq_writer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: n counts cycles since the accepted start; the write
    // schedule is a fixed offset from the calculation length.
    logic         m_active;
    int           m_n;
    int           m_lat;
    logic [W-1:0] m_q;
    logic [W-1:0] m_r;
    logic         m_dbz;
    logic [W-1:0] h_data;
    logic         h_sel;
    int           m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_lat    <= 0;
            m_dbz    <= 1'b0;
            h_data   <= '0;
            h_sel    <= 1'b0;
        end else if (m_active) begin
            if (m_n == m_lat + 5) m_active <= 1'b0;
            else m_n <= m_n + 1;
            if (m_n + 1 == m_lat + 1) begin
                h_data <= m_q;
                h_sel  <= 1'b0;
            end
            if (m_n + 1 == m_lat + 3) begin
                h_data <= m_r;
                h_sel  <= 1'b1;
            end
        end else if (bus.start) begin
            m_active <= 1'b1;
            m_n      <= 1;
            m_acc    <= m_acc + 1;
            m_dbz    <= (bus.divisor == 0);
            if (bus.divisor == 0) begin
                m_lat  <= 0;
                m_q    <= '1;
                m_r    <= bus.dividend;
                h_data <= '1;
                h_sel  <= 1'b0;
            end else begin
                m_lat  <= W;
                m_q    <= bus.dividend / bus.divisor;
                m_r    <= bus.dividend % bus.divisor;
            end
        end
    end

    logic e_wr, e_busy, e_done;
    always_comb begin
        e_wr   = m_active && ((m_n == m_lat + 2) || (m_n == m_lat + 4));
        e_busy = m_active && (m_n <= m_lat + 4);
        e_done = m_active && (m_n == m_lat + 5);
    end

    logic         pw;
    logic [W-1:0] pd;
    logic         ps;

    always @(negedge clk) begin
        if (rst) begin
            pw <= 1'b0;
            pd <= '0;
            ps <= 1'b0;
        end else begin
            chk("wr", bus.wr, e_wr);
            chk("wr_sel", bus.wr_sel, h_sel);
            chk("wr_data", bus.wr_data, h_data);
            chk("busy", bus.busy, e_busy);
            chk("done", bus.done, e_done);
            chk("div_by_zero", bus.div_by_zero, m_dbz);
            if (bus.wr && !pw) begin
                chk("wr_data_stable", bus.wr_data, pd);
                chk("wr_sel_stable", bus.wr_sel, ps);
            end
            pw <= bus.wr;
            pd <= bus.wr_data;
            ps <= bus.wr_sel;
        end
    end

    task automatic run_dir(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int edone, input logic edbz, input bit glitch);
        int           qcyc = 0;
        int           rcyc = 0;
        int           dcyc = 0;
        logic [W-1:0] qd = '0;
        logic [W-1:0] rd = '0;
        logic         qs = 1'b1;
        logic         rs = 1'b0;
        logic         dz = 1'b0;
        logic         prev = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                bus.start = 1'b0;
                bus.dividend = 16'($urandom);
                bus.divisor = 16'($urandom);
            end
            if (glitch && cyc == 8) begin
                bus.start = 1'b1;
                bus.dividend = 16'h0005;
                bus.divisor = 16'h0000;
            end
            if (glitch && cyc == 9) bus.start = 1'b0;
            if (bus.wr && !prev) begin
                if (qcyc == 0) begin
                    qcyc = cyc; qd = bus.wr_data; qs = bus.wr_sel;
                end else if (rcyc == 0) begin
                    rcyc = cyc; rd = bus.wr_data; rs = bus.wr_sel;
                end
            end
            if (bus.done && dcyc == 0) begin
                dcyc = cyc; dz = bus.div_by_zero;
            end
            prev = bus.wr;
        end
        chk({nm, "_q_cycle"}, qcyc, edone - 3);
        chk({nm, "_q_data"}, qd, eq);
        chk({nm, "_q_sel"}, qs, 1'b0);
        chk({nm, "_r_cycle"}, rcyc, edone - 1);
        chk({nm, "_r_data"}, rd, er);
        chk({nm, "_r_sel"}, rs, 1'b1);
        chk({nm, "_done_cycle"}, dcyc, edone);
        chk({nm, "_dbz"}, dz, edbz);
    endtask

    initial begin
        int guard;
        int acc0;
        bit saw_wr;
        m_acc = 0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        chk("rst_wr", bus.wr, 0);
        chk("rst_wr_sel", bus.wr_sel, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;

        run_dir("div_100_7", 16'd100, 16'd7, 16'd14, 16'd2, 21, 1'b0, 1'b0);
        run_dir("div_ffff_1", 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 21, 1'b0, 1'b0);
        run_dir("div_3_10", 16'h0003, 16'h000A, 16'h0000, 16'h0003, 21, 1'b0, 1'b0);
        run_dir("div_5_0", 16'h0005, 16'h0000, 16'hFFFF, 16'h0005, 5, 1'b1, 1'b0);
        run_dir("ignored_start", 16'd100, 16'd7, 16'd14, 16'd2, 21, 1'b0, 1'b1);

        // Abort mid-calculation with an asynchronous reset
        @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor = 16'd7;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
        end
        chk("pre_abort_busy", bus.busy, 1);
        #3 rst = 1'b1;
        #1;
        chk("abort_wr", bus.wr, 0);
        chk("abort_wr_sel", bus.wr_sel, 0);
        chk("abort_wr_data", bus.wr_data, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_dbz", bus.div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_wr = 1'b0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge clk);
            if (bus.wr) saw_wr = 1'b1;
        end
        chk("abort_no_wr", saw_wr, 0);
        run_dir("div_9_4", 16'd9, 16'd4, 16'd2, 16'd1, 21, 1'b0, 1'b0);

        // Random traffic: start toggles freely, including while busy
        acc0 = m_acc;
        guard = 0;
        while ((m_acc - acc0 < c_RAND_OPS) && (guard < c_RAND_LIMIT)) begin
            @(negedge clk);
            guard++;
            bus.start = ($urandom_range(0, 3) != 0);
            bus.dividend = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       bus.divisor = 16'h0000;
                1, 2:    bus.divisor = 16'($urandom_range(1, 15));
                3: begin
                    bus.divisor = 16'($urandom);
                    bus.dividend = 16'($urandom_range(0, 255));
                end
                default: bus.divisor = 16'($urandom);
            endcase
        end
        if (guard >= c_RAND_LIMIT) begin
            n_chk++;
            n_fail++;
            $display("FAIL random_timeout: got %0d operations, expected %0d", m_acc - acc0, c_RAND_OPS);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (30) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_seq_writer.md
DIV_SEQ_WRITER -- requirements
Module: div_seq_writer

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and result width.
REQ-002 SHALL provide port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port start  input  1  begin a division; sampled only in IDLE.
REQ-005 SHALL provide port dividend  input  WIDTH  unsigned dividend; captured on accepted start.
REQ-006 SHALL provide port divisor  input  WIDTH  unsigned divisor; captured on accepted start.
REQ-007 SHALL provide port wr_data  output  WIDTH  result word driven to the quotient/remainder register pair.
REQ-008 SHALL provide port wr_sel  output  1  target register select: 0 = quotient, 1 = remainder.
REQ-009 SHALL provide port wr  output  1  write strobe; the register pair latches wr_data on wr rising edge.
REQ-010 SHALL provide port busy  output  1  high from the accepted start through the last write strobe.
REQ-011 SHALL provide port done  output  1  single-cycle completion pulse.
REQ-012 SHALL provide port div_by_zero  output  1  status for the last division; high if divisor was 0.

Function
REQ-013 SHALL implement states IDLE, CALC, Q_SETUP, Q_STROBE, R_SETUP, R_STROBE, FIN.
REQ-014 SHALL, in IDLE with start=1, capture dividend and divisor, set busy, and clear div_by_zero.
REQ-015 SHALL, on an accepted start with divisor != 0, enter CALC; with divisor == 0, enter Q_SETUP directly.
REQ-016 SHALL perform unsigned restoring division in CALC, one quotient bit per cycle, MSB first, for exactly WIDTH cycles.
REQ-017 SHALL use a WIDTH+1-bit partial remainder so that the trial subtraction never overflows.
REQ-018 SHALL, for divisor == 0, produce quotient = all ones and remainder = captured dividend, and set div_by_zero.
REQ-019 SHALL, in Q_SETUP, drive wr_data = quotient, wr_sel = 0 and wr = 0.
REQ-020 SHALL, in Q_STROBE, hold wr_data and wr_sel and drive wr = 1.
REQ-021 SHALL, in R_SETUP, drive wr_data = remainder, wr_sel = 1 and wr = 0.
REQ-022 SHALL, in R_STROBE, hold wr_data and wr_sel and drive wr = 1.
REQ-023 SHALL never change wr_data or wr_sel in the same cycle that wr rises; data is stable one full cycle before each wr rising edge.
REQ-024 SHALL, in FIN, drive done = 1, busy = 0 and wr = 0 for exactly one cycle, then return to IDLE.
REQ-025 SHALL set timing for a nonzero divisor (start accepted at edge 0) as follows: CALC on cycles 1..WIDTH; Q_SETUP, Q_STROBE, R_SETUP, R_STROBE on WIDTH+1..WIDTH+4; done on WIDTH+5 (cycle 21 for WIDTH=16).
REQ-026 SHALL set timing for a zero divisor as follows: Q_SETUP on cycle 1; done on cycle 5.
REQ-027 SHALL ignore start while busy or in FIN; captured operands are unaffected.
REQ-028 SHALL accept a start asserted in the cycle after FIN; no extra idle cycle is required.
REQ-029 SHALL register all outputs (no combinational path from inputs to wr, wr_sel or wr_data).
REQ-030 SHALL hold wr_data and wr_sel at their last values in IDLE; div_by_zero persists until the next accepted start.

Reset
REQ-031 SHALL, on rst=1, immediately force state IDLE, wr=0, wr_sel=0, wr_data=0, busy=0, done=0, div_by_zero=0, and clear internal quotient, remainder and counter.
REQ-032 SHALL, on rst mid-operation (any state), abort the division with no further wr pulse; a wr already high drops asynchronously.
REQ-033 SHALL, after rst deasserts, ignore start until the first rising clk edge with rst low.

Verification
REQ-034 SHALL verify: dividend=100, divisor=7 -> wr pulse on cycle 18 with wr_data=14, wr_sel=0; wr pulse on cycle 20 with wr_data=2, wr_sel=1; done on cycle 21; div_by_zero=0.
REQ-035 SHALL verify: 0xFFFF / 0x0001 -> quotient 0xFFFF, remainder 0x0000; and 0x0003 / 0x000A -> quotient 0x0000, remainder 0x0003.
REQ-036 SHALL verify: 0x0005 / 0x0000 -> quotient 0xFFFF on cycle 2, remainder 0x0005 on cycle 4, done on cycle 5, div_by_zero=1.
REQ-037 SHALL verify: start pulsed again on cycle 8 with other operands -> ignored; results match the first operands.
REQ-038 SHALL verify: rst asserted on cycle 10 (CALC) -> all outputs 0 immediately; no wr pulse; next start divides 9/4 -> quotient 2, remainder 1.
REQ-039 SHALL verify at every wr rising edge that wr_data and wr_sel equal their values from the previous cycle, checked across 1000 random operand pairs against a reference model.
